// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage
//   Inter-stage pipeline register with a valid/ready handshake. When PASSTHRU=0
//   it is a two-entry skid stage: a main register that drives the output and a
//   skid register that catches the beat accepted while the downstream stalls.
//   Because of the skid register, in_ready depends only on registered state and
//   the stage still sustains one beat per cycle. When PASSTHRU=1 the stage is
//   plain wires and the only register is the stall counter.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous reset, active-low
//   flush         synchronous squash of every held entry
//   in_valid      upstream offers in_data
//   in_ready      stage can accept this cycle (registered when PASSTHRU=0)
//   in_data       upstream payload, WIDTH bits
//   out_valid     out_data holds a live entry
//   out_ready     downstream consumes this cycle
//   out_data      head-entry payload
//   occupancy     entries held: 0, 1 or 2
//   stall_cycles  consecutive cycles with out_valid & !out_ready, saturating
module pipe_skid_stage #(
    parameter int unsigned WIDTH    = 96,
    parameter int unsigned PASSTHRU = 0,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    logic in_xfer;
    logic out_xfer;
    logic stall_clr;

    always_comb begin
        in_xfer   = in_valid & in_ready;
        out_xfer  = out_valid & out_ready;
        stall_clr = flush | ~out_valid | out_ready;
    end

    // Stall counter: common to both build modes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
        end else if (stall_clr) begin
            stall_cycles <= '0;
        end else if (stall_cycles != '1) begin
            stall_cycles <= stall_cycles + CNT_ONE;
        end
    end

    generate
        if (PASSTHRU != 0) begin : g_passthru
            always_comb begin
                out_valid = in_valid & ~flush;
                in_ready  = out_ready;
                out_data  = in_data;
                occupancy = '0;
            end
        end else begin : g_skid
            state_t           state_q;
            state_t           state_d;
            logic [WIDTH-1:0] main_q;
            logic [WIDTH-1:0] skid_q;

            // State register
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    state_q <= EMPTY;
                end else begin
                    state_q <= state_d;
                end
            end

            // Next-state logic; flush overrides every transition
            always_comb begin
                state_d = state_q;
                unique case (state_q)
                    EMPTY: if (in_xfer) state_d = BUSY;
                    BUSY: begin
                        if (in_xfer && !out_xfer)      state_d = FULL;
                        else if (!in_xfer && out_xfer) state_d = EMPTY;
                    end
                    FULL:    if (out_xfer) state_d = BUSY;
                    default: state_d = EMPTY;
                endcase
                if (flush) state_d = EMPTY;
            end

            // Payload registers; left untouched on flush since they are
            // don't-care once the state returns to EMPTY.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    main_q <= '0;
                    skid_q <= '0;
                end else if (!flush) begin
                    unique case (state_q)
                        EMPTY: if (in_xfer) main_q <= in_data;
                        BUSY: begin
                            if (in_xfer && out_xfer) main_q <= in_data;
                            else if (in_xfer)        skid_q <= in_data;
                        end
                        FULL:    if (out_xfer) main_q <= skid_q;
                        default: ;
                    endcase
                end
            end

            // Outputs decoded from registered state only, so no path from
            // out_ready reaches in_ready.
            always_comb begin
                out_data = main_q;
                unique case (state_q)
                    BUSY: begin
                        in_ready  = 1'b1;
                        out_valid = 1'b1;
                        occupancy = 2'd1;
                    end
                    FULL: begin
                        in_ready  = 1'b0;
                        out_valid = 1'b1;
                        occupancy = 2'd2;
                    end
                    default: begin
                        in_ready  = 1'b1;
                        out_valid = 1'b0;
                        occupancy = 2'd0;
                    end
                endcase
            end
        end
    endgenerate

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage. Three instances share one stimulus stream:
//   A: default skid stage (CNT_W=8), B: skid stage with CNT_W=4,
//   C: PASSTHRU=1. A queue model predicts all three every cycle.
module tb_pipe_skid_stage;

    localparam int W = 96;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         out_ready;

    logic         a_in_ready, a_out_valid;
    logic [W-1:0] a_out_data;
    logic [1:0]   a_occ;
    logic [7:0]   a_stall;

    logic         b_in_ready, b_out_valid;
    logic [W-1:0] b_out_data;
    logic [1:0]   b_occ;
    logic [3:0]   b_stall;

    logic         c_in_ready, c_out_valid;
    logic [W-1:0] c_out_data;
    logic [1:0]   c_occ;
    logic [7:0]   c_stall;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipe_skid_stage #(.WIDTH(W), .PASSTHRU(0), .CNT_W(8)) u_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .occupancy(a_occ), .stall_cycles(a_stall)
    );

    pipe_skid_stage #(.WIDTH(W), .PASSTHRU(0), .CNT_W(4)) u_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .occupancy(b_occ), .stall_cycles(b_stall)
    );

    pipe_skid_stage #(.WIDTH(W), .PASSTHRU(1), .CNT_W(8)) u_c (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(c_in_ready), .in_data(in_data),
        .out_valid(c_out_valid), .out_ready(out_ready), .out_data(c_out_data),
        .occupancy(c_occ), .stall_cycles(c_stall)
    );

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [W-1:0] mq[$];   // entries held by the skid stage, head first
    int m_sa, m_sb, m_sc;  // stall counters for A, B, C

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            m_sa = 0; m_sb = 0; m_sc = 0;
        end else begin
            bit ov, acc, cv;
            ov  = mq.size() > 0;
            acc = in_valid && (mq.size() < 2);
            cv  = in_valid && !flush;
            if (flush || !ov || out_ready) begin
                m_sa = 0; m_sb = 0;
            end else begin
                if (m_sa < 255) m_sa++;
                if (m_sb < 15)  m_sb++;
            end
            if (flush || !cv || out_ready) m_sc = 0;
            else if (m_sc < 255)           m_sc++;
            if (flush) mq.delete();
            else begin
                if (ov && out_ready) void'(mq.pop_front());
                if (acc)             mq.push_back(in_data);
            end
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_a_valid", W'(a_out_valid), '0);
            chk("rst_a_ready", W'(a_in_ready), W'(1));
            chk("rst_a_occ",   W'(a_occ), '0);
            chk("rst_a_stall", W'(a_stall), '0);
            chk("rst_b_stall", W'(b_stall), '0);
            chk("rst_c_stall", W'(c_stall), '0);
        end else begin
            chk("a_valid", W'(a_out_valid), W'(mq.size() > 0));
            chk("a_ready", W'(a_in_ready),  W'(mq.size() < 2));
            chk("a_occ",   W'(a_occ),       W'(mq.size()));
            chk("a_stall", W'(a_stall),     W'(m_sa));
            chk("b_valid", W'(b_out_valid), W'(mq.size() > 0));
            chk("b_occ",   W'(b_occ),       W'(mq.size()));
            chk("b_stall", W'(b_stall),     W'(m_sb));
            if (mq.size() > 0) begin
                chk("a_data", a_out_data, mq[0]);
                chk("b_data", b_out_data, mq[0]);
            end
            chk("c_valid", W'(c_out_valid), W'(in_valid && !flush));
            chk("c_ready", W'(c_in_ready),  W'(out_ready));
            chk("c_data",  c_out_data,      in_data);
            chk("c_occ",   W'(c_occ),       '0);
            chk("c_stall", W'(c_stall),     W'(m_sc));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = W'(32'h99); out_ready = 1'b0;

        // 1: reset holds the stage empty even with in_valid asserted
        step(); step();
        chk("t1_valid", W'(a_out_valid), '0);
        chk("t1_ready", W'(a_in_ready), W'(1));
        chk("t1_occ",   W'(a_occ), '0);
        chk("t1_stall", W'(a_stall), '0);
        rst = 1'b1; in_valid = 1'b0;
        step();
        chk("t1_after", W'(a_out_valid), '0);

        // 2: streaming, one cycle latency, occupancy stays 1
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = W'(i);
            step();
            chk("t2_data",  a_out_data, W'(i));
            chk("t2_occ",   W'(a_occ), W'(1));
            chk("t2_ready", W'(a_in_ready), W'(1));
        end
        in_valid = 1'b0;
        step();
        chk("t2_drain", W'(a_out_valid), '0);

        // 3: backpressure fills both entries; counter runs 1,2,3
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = W'(32'hA);
        step();
        chk("t3_stall0", W'(a_stall), '0);
        in_data = W'(32'hB);
        step();
        chk("t3_occ",    W'(a_occ), W'(2));
        chk("t3_ready",  W'(a_in_ready), '0);
        chk("t3_stall1", W'(a_stall), W'(1));
        in_valid = 1'b0;
        step();
        chk("t3_stall2", W'(a_stall), W'(2));
        step();
        chk("t3_stall3", W'(a_stall), W'(3));
        chk("t3_headA",  a_out_data, W'(32'hA));
        out_ready = 1'b1;
        step();
        chk("t3_headB",  a_out_data, W'(32'hB));
        chk("t3_clr",    W'(a_stall), '0);
        chk("t3_occ1",   W'(a_occ), W'(1));
        step();
        chk("t3_empty",  W'(a_out_valid), '0);

        // 4: flush from FULL discards a simultaneous input
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = W'(32'hA);
        step();
        in_data = W'(32'hB);
        step();
        chk("t4_full", W'(a_occ), W'(2));
        flush = 1'b1; in_data = W'(32'hC);
        step();
        chk("t4_valid", W'(a_out_valid), '0);
        chk("t4_occ",   W'(a_occ), '0);
        chk("t4_ready", W'(a_in_ready), W'(1));
        chk("t4_stall", W'(a_stall), '0);
        flush = 1'b0; in_valid = 1'b0;
        step();
        chk("t4_noC", W'(a_out_valid), '0);

        // 5: saturation; B (CNT_W=4) sticks at 15 while A reaches 20
        in_valid = 1'b1; in_data = W'(32'h5A);
        step();
        in_valid = 1'b0;
        repeat (20) step();
        chk("t5_b_sat", W'(b_stall), W'(15));
        chk("t5_a_20",  W'(a_stall), W'(20));
        out_ready = 1'b1;
        step();
        chk("t5_b_clr", W'(b_stall), '0);
        chk("t5_a_clr", W'(a_stall), '0);

        // 6: passthrough is combinational
        in_valid = 1'b1; in_data = W'(32'h55); out_ready = 1'b0; flush = 1'b0;
        #1;
        chk("t6_valid", W'(c_out_valid), W'(1));
        chk("t6_data",  c_out_data, W'(32'h55));
        chk("t6_ready", W'(c_in_ready), '0);
        flush = 1'b1;
        #1;
        chk("t6_flush", W'(c_out_valid), '0);
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();

        // mixed traffic with one flush, checked by the model only
        for (int i = 0; i < 40; i++) begin
            in_valid  = (i % 3) != 0;
            out_ready = (i % 4) != 1;
            flush     = (i == 25);
            in_data   = W'(32'h100 + i);
            step();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step(); step();

        // reset mid-operation loses held entries at once
        out_ready = 1'b0; in_valid = 1'b1; in_data = W'(32'h77);
        step(); step();
        rst = 1'b0;
        #1;
        chk("rst_mid_valid", W'(a_out_valid), '0);
        chk("rst_mid_occ",   W'(a_occ), '0);
        step();
        rst = 1'b1; in_valid = 1'b0;
        step(); step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
